// File: rtl/mult_booth4_pkg.sv
// Shared types and helpers for the sequential radix-4 Booth multiplier.
// Holds the controller state encoding, the Booth digit flags and the digit-count function.
package mult_booth4_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // One radix-4 Booth digit: magnitude is one or two (or zero if neither), neg gives the sign.
    typedef struct packed {
        logic neg;
        logic one;
        logic two;
    } booth_digit_t;

    // Number of radix-4 digits needed to cover a WIDTH+2 bit extended multiplier.
    function automatic int booth_digits(input int width);
        return width / 2 + 1;
    endfunction

endpackage

// File: rtl/mult_booth4_digit.sv
// Combinational radix-4 Booth digit: encodes one multiplier triplet and forms the
// sign-extended (WIDTH+3)-bit partial product from the extended multiplicand.
module mult_booth4_digit
    import mult_booth4_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [2:0]       triplet,
    input  logic [WIDTH+1:0] x_ext,
    output logic [WIDTH+2:0] partial
);

    booth_digit_t     digit;
    logic [WIDTH+2:0] magnitude;

    // 111 encodes -0, so neg is suppressed there to keep the partial product a clean zero.
    always_comb begin
        digit     = '0;
        digit.neg = triplet[2] & ~(triplet[1] & triplet[0]);
        digit.one = triplet[1] ^ triplet[0];
        digit.two = (triplet == 3'b011) | (triplet == 3'b100);
    end

    always_comb begin
        magnitude = '0;
        if (digit.one) begin
            magnitude = {x_ext[WIDTH+1], x_ext};
        end else if (digit.two) begin
            magnitude = {x_ext, 1'b0};
        end
        partial = digit.neg ? (~magnitude + 1'b1) : magnitude;
    end

endmodule

// File: rtl/mult_booth4_seq.sv
// Sequential radix-4 Booth multiplier: one digit retired per cycle, valid/ready on both sides,
// signed or unsigned operands selected per transaction.
module mult_booth4_seq
    import mult_booth4_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    input  logic                 is_signed,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product
);

    localparam int K  = booth_digits(WIDTH);
    localparam int CW = $clog2(K + 1);
    localparam int AW = 2 * WIDTH + 4;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH+1:0] x_q;
    logic [WIDTH+2:0] y_q;
    logic [AW-1:0]    acc_q;
    logic [CW-1:0]    cnt_q;

    logic             accept;
    logic             release_out;
    logic             last_digit;
    logic [WIDTH+1:0] x_ext_in;
    logic [WIDTH+2:0] y_ext_in;
    logic [WIDTH+2:0] partial;
    logic [AW-1:0]    partial_wide;
    logic [AW-1:0]    partial_shifted;
    logic             acc_guard_unused;

    assign in_ready    = (state_q == IDLE);
    assign out_valid   = (state_q == DONE);
    assign accept      = in_valid & in_ready;
    assign release_out = out_valid & out_ready;
    assign last_digit  = (cnt_q == CW'(K - 1));

    // The extension mode is folded into the latched operands, so is_signed needs no register of its own.
    assign x_ext_in = is_signed ? {{2{multiplicand[WIDTH-1]}}, multiplicand}
                                : {2'b00, multiplicand};
    assign y_ext_in = is_signed ? {{2{multiplier[WIDTH-1]}}, multiplier, 1'b0}
                                : {2'b00, multiplier, 1'b0};

    mult_booth4_digit #(
        .WIDTH (WIDTH)
    ) u_digit (
        .triplet (y_q[2:0]),
        .x_ext   (x_q),
        .partial (partial)
    );

    assign partial_wide    = {{(WIDTH + 1){partial[WIDTH+2]}}, partial};
    assign partial_shifted = partial_wide << {cnt_q, 1'b0};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (last_digit) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (release_out) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Clearing the accumulator on release keeps product at zero throughout IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q   <= '0;
            y_q   <= '0;
            acc_q <= '0;
            cnt_q <= '0;
        end else begin
            if (accept) begin
                x_q   <= x_ext_in;
                y_q   <= y_ext_in;
                acc_q <= '0;
                cnt_q <= '0;
            end else if (state_q == BUSY) begin
                acc_q <= acc_q + partial_shifted;
                y_q   <= y_q >> 2;
                cnt_q <= cnt_q + CW'(1);
            end else if (release_out) begin
                acc_q <= '0;
                cnt_q <= '0;
            end
        end
    end

    assign product          = acc_q[2*WIDTH-1:0];
    assign acc_guard_unused = ^acc_q[AW-1:2*WIDTH];

endmodule

// File: doc/mult_booth4_seq.md
MULT_BOOTH4_SEQ -- requirements
Module: mult_booth4_seq

Interface
REQ-001 Parameter WIDTH, default 16: operand width in bits; SHALL be even and >= 4.
REQ-002 clk  input  1  sole clock; all state SHALL update on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  operand set offered.
REQ-005 in_ready  output  1  block can accept an operand set.
REQ-006 multiplicand  input  WIDTH  X operand.
REQ-007 multiplier  input  WIDTH  Y operand.
REQ-008 is_signed  input  1  1 = both operands two's complement; 0 = both unsigned.
REQ-009 out_valid  output  1  product is available.
REQ-010 out_ready  input  1  consumer takes the product.
REQ-011 product  output  2*WIDTH  X*Y, signed or unsigned per the latched is_signed.

Function
REQ-012 The block SHALL use an FSM with three states, IDLE, BUSY and DONE; reset state is IDLE.
REQ-013 in_ready SHALL be 1 exactly in IDLE; out_valid SHALL be 1 exactly in DONE.
REQ-014 Accept happens when in_valid & in_ready at a clock edge:
- latch multiplicand, multiplier and is_signed;
- clear the accumulator and the digit counter;
- go to BUSY.
REQ-015 Operand extension on accept:
- multiplicand is extended to WIDTH+2 bits;
- multiplier is extended to WIDTH+2 bits, with an implicit 0 appended below its LSB;
- extension is sign-extension when is_signed=1 and zero-extension when is_signed=0.
REQ-016 BUSY SHALL retire one radix-4 Booth digit per cycle, for K = WIDTH/2+1 cycles. Each cycle:
- take the next overlapping triplet (y[2i+1], y[2i], y[2i-1]), LSB first;
- encode it to a digit in {0, +1, +2, -1, -2}, with -0 treated as 0;
- add digit * multiplicand * 4^i to a 2*WIDTH+4-bit accumulator, with full sign extension of the partial product.
REQ-017 After the K-th BUSY cycle the FSM SHALL enter DONE, so out_valid rises exactly K edges after the accepting edge (WIDTH=16 gives K=9).
REQ-018 product SHALL equal accumulator[2*WIDTH-1:0]; it SHALL be bit-exact against the mathematical product for all operand pairs in both modes.
REQ-019 In DONE:
- product SHALL stay stable while out_ready=0, for any number of cycles;
- out_valid & out_ready at an edge SHALL return the FSM to IDLE.
REQ-020 in_valid SHALL be ignored outside IDLE; inputs are never sampled in BUSY or DONE.
REQ-021 Changing is_signed or the operands after accept SHALL NOT affect the result in flight.
REQ-022 product SHALL read 0 in IDLE.

Reset
REQ-023 When rst_n=0 the following SHALL hold immediately, independent of clk:
- state=IDLE, in_ready=1, out_valid=0;
- product=0, accumulator=0, counter=0.
REQ-024 Reset asserted in BUSY or DONE SHALL abort the operation and drop the pending result.
REQ-025 After reset deassertion the first accept SHALL behave exactly as an accept from power-up.

Structure
REQ-026 Package mult_booth4_pkg SHALL hold:
- the FSM state enum;
- the Booth digit typedef (neg, one, two flags);
- a function giving K from WIDTH.
REQ-027 Sub-module mult_booth4_digit SHALL be purely combinational:
- encodes one triplet;
- produces the sign-extended (WIDTH+3)-bit partial product from the extended multiplicand;
- is instantiated once and reused on every BUSY cycle.
REQ-028 The accumulator adder SHALL be a plain behavioural add; no compressor tree.

Verification (WIDTH=8, K=5)
REQ-029 Unsigned 0xFF * 0xFF, accepted at edge t -> out_valid at edge t+5, product=0xFE01.
REQ-030 Signed 0x80 * 0x80 -> product=0x4000; signed 0xFF * 0x01 -> product=0xFFFF; unsigned 0xFF * 0x01 -> product=0x00FF.
REQ-031 Backpressure test:
- stimulus: out_ready=0 for 6 cycles in DONE, with in_valid=1 throughout;
- response: product held, in_ready=0, no second accept;
- on the out_ready=1 edge: IDLE, then the next accept on the following edge.
REQ-032 Reset mid-operation: rst_n pulsed low during the third BUSY cycle -> out_valid=0 and in_ready=1 immediately, and no stale product afterwards.
REQ-033 Input change in flight: operands and is_signed toggled every cycle during BUSY -> the result matches the latched values.
REQ-034 Randomised test: 10k random pairs in mixed modes with random out_ready -> every product matches the reference model, with latency always exactly K.
